result_bcd_converter: RTL

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

---
 rtl/result_bcd_converter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: turns an unsigned BIN_W-bit product into
// five packed BCD digits plus a leading-zero blanking mask for the display.
// One add-3/shift iteration runs per clock; latency is fixed at BIN_W cycles.
module result_bcd_converter #(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [19:0]      bcd,
    output logic [4:0]       lz_blank
);

    // Counter must be able to reach BIN_W without wrapping.
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [19:0]      scratch;
    logic [BIN_W-1:0] binsh;
    logic [CW-1:0]    cnt;

    logic [19:0]      adj;
    logic [19:0]      scratch_nxt;
    logic [BIN_W-1:0] binsh_nxt;
    logic [4:0]       lz_nxt;
    logic [4:0]       dig_zero;

    logic             load;
    logic             step;
    logic             last;

    // Add-3 correction on every scratch digit that is 5 or more.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch[4*i +: 4];
            end
        end
    end

    // Shift the combined {scratch, binary} register left by one bit.
    always_comb begin
        {scratch_nxt, binsh_nxt} = {adj, binsh} << 1;
    end

    // Blank mask for the digits the final iteration will produce; a digit is
    // suppressed only when it and every more-significant digit are zero.
    always_comb begin
        dig_zero = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            dig_zero[i] = (scratch_nxt[4*i +: 4] == 4'd0);
        end
        lz_nxt    = '0;
        lz_nxt[4] = dig_zero[4];
        lz_nxt[3] = dig_zero[4] & dig_zero[3];
        lz_nxt[2] = dig_zero[4] & dig_zero[3] & dig_zero[2];
        lz_nxt[1] = dig_zero[4] & dig_zero[3] & dig_zero[2] & dig_zero[1];
        lz_nxt[0] = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_ITER) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in CONV, publish on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch  <= '0;
            binsh    <= '0;
            cnt      <= '0;
            bcd      <= '0;
            lz_blank <= 5'b11110;
        end else if (load) begin
            scratch <= '0;
            binsh   <= bin;
            cnt     <= '0;
        end else if (step) begin
            scratch <= scratch_nxt;
            binsh   <= binsh_nxt;
            cnt     <= cnt + CW'(1);
            if (last) begin
                bcd      <= scratch_nxt;
                lz_blank <= lz_nxt;
            end
        end
    end

endmodule
